chan_reg_bank: RTL and testbench

CHAN_REG_BANK -- requirements
Module: chan_reg_bank

---
 rtl/chan_reg_pkg.sv | 19 +
 rtl/chan_reg_bank_snapshot.sv | 48 ++++
 rtl/chan_reg_bank.sv | 126 ++++++++++++
 tb/tb_chan_reg_bank.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/chan_reg_pkg.sv
// Shared constants for the channel register bank: address-map offsets
// and the per-channel snapshot FSM encoding.
package chan_reg_pkg;

  localparam logic [2:0] CH_OFF_CNT0     = 3'd0;
  localparam logic [2:0] CH_OFF_CFG      = 3'd5;

  localparam logic [2:0] GL_OFF_HWCFG    = 3'd0;
  localparam logic [2:0] GL_OFF_WDOGDIV  = 3'd1;
  localparam logic [2:0] GL_OFF_CTRL     = 3'd2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HOLD = 2'd1,
    S_CAPT = 2'd2,
    S_LOCK = 2'd3
  } snap_state_e;

endpackage

// File: rtl/chan_reg_bank_snapshot.sv
// One channel's snapshot engine: holds the tach counter for two cycles,
// captures it into snap, and keeps it locked until the read transaction ends.
module chan_snapshot
  import chan_reg_pkg::*;
#(
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_start,
  input  logic            i_rdt_sync,
  input  logic [CNTW-1:0] i_count,
  output logic            o_freeze,
  output logic            o_use_snap,
  output logic [CNTW-1:0] o_snap
);

  snap_state_e     r_state;
  snap_state_e     w_next;
  logic [CNTW-1:0] r_snap;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_snap  <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_CAPT) r_snap <= i_count;
    end
  end

  // A start while busy is ignored; only the end of the read releases LOCK.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (i_start) w_next = S_HOLD;
      S_HOLD:  w_next = S_CAPT;
      S_CAPT:  w_next = S_LOCK;
      S_LOCK:  if (!i_rdt_sync) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  assign o_freeze   = (r_state == S_HOLD) || (r_state == S_CAPT);
  assign o_use_snap = (r_state == S_CAPT) || (r_state == S_LOCK);
  assign o_snap     = r_snap;

endmodule

// File: rtl/chan_reg_bank.sv
// SPI-facing register bank for NCHAN motor channels: synchronizes the
// transaction levels, decodes write/read strobes and muxes readback data.
module chan_reg_bank
  import chan_reg_pkg::*;
#(
  parameter int NCHAN = 3,
  parameter int CNTW  = 16,
  parameter int ADDRW = $clog2(NCHAN*8+8)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wrt,
  input  logic                  rdt,
  input  logic [ADDRW-1:0]      addr,
  input  logic [NCHAN*CNTW-1:0] count,
  input  logic [NCHAN*8-1:0]    configrd,
  input  logic [7:0]            hwconfig,
  input  logic [7:0]            controlrdata,
  output logic [7:0]            rddata,
  output logic [NCHAN-1:0]      pwmld,
  output logic [NCHAN-1:0]      cfgld,
  output logic [NCHAN-1:0]      freeze,
  output logic                  ctrlld,
  output logic                  wdogdivld,
  output logic                  wdreset
);

  localparam int NBYTE = CNTW / 8;
  localparam int BLKW  = ADDRW - 3;

  logic r_wrt_s1, r_wrt_s2, r_wrt_d;
  logic r_rdt_s1, r_rdt_s2, r_rdt_d;
  logic w_wr_fall, w_rd_rise;

  logic [BLKW-1:0] w_blk;
  logic [2:0]      w_off;
  logic            w_glob;
  logic [NCHAN-1:0] w_chsel, w_freeze, w_use_snap;
  logic [NCHAN*CNTW-1:0] w_snap;

  logic [NCHAN-1:0] r_pwmld, r_cfgld;
  logic             r_ctrlld, r_wdogdivld, r_wdreset;

  assign w_blk     = addr[ADDRW-1:3];
  assign w_off     = addr[2:0];
  assign w_glob    = (w_blk == BLKW'(NCHAN));
  assign w_wr_fall = r_wrt_d & ~r_wrt_s2;
  assign w_rd_rise = r_rdt_s2 & ~r_rdt_d;

  // Strobes land on the third edge that samples a fallen wrt (counting the
  // edge that loads the first synchronizer flop); addr is sampled there too.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wrt_s1    <= 1'b0;
      r_wrt_s2    <= 1'b0;
      r_wrt_d     <= 1'b0;
      r_rdt_s1    <= 1'b0;
      r_rdt_s2    <= 1'b0;
      r_rdt_d     <= 1'b0;
      r_pwmld     <= '0;
      r_cfgld     <= '0;
      r_ctrlld    <= 1'b0;
      r_wdogdivld <= 1'b0;
      r_wdreset   <= 1'b0;
    end else begin
      r_wrt_s1    <= wrt;
      r_wrt_s2    <= r_wrt_s1;
      r_wrt_d     <= r_wrt_s2;
      r_rdt_s1    <= rdt;
      r_rdt_s2    <= r_rdt_s1;
      r_rdt_d     <= r_rdt_s2;
      for (int c = 0; c < NCHAN; c++) begin
        r_pwmld[c] <= w_wr_fall && w_chsel[c] && (w_off == CH_OFF_CNT0);
        r_cfgld[c] <= w_wr_fall && w_chsel[c] && (w_off == CH_OFF_CFG);
      end
      r_wdogdivld <= w_wr_fall && w_glob && (w_off == GL_OFF_WDOGDIV);
      r_ctrlld    <= w_wr_fall && w_glob && (w_off == GL_OFF_CTRL);
      r_wdreset   <= w_rd_rise && w_glob && (w_off == GL_OFF_CTRL);
    end
  end

  for (genvar c = 0; c < NCHAN; c++) begin : g_chan
    assign w_chsel[c] = (w_blk == BLKW'(c));

    chan_snapshot #(.CNTW(CNTW)) u_snap (
      .clk        (clk),
      .rst        (rst),
      .i_start    (w_rd_rise && w_chsel[c] && (w_off == CH_OFF_CNT0)),
      .i_rdt_sync (r_rdt_s2),
      .i_count    (count[c*CNTW +: CNTW]),
      .o_freeze   (w_freeze[c]),
      .o_use_snap (w_use_snap[c]),
      .o_snap     (w_snap[c*CNTW +: CNTW])
    );
  end

  // Byte 0 follows the live counter until capture; higher bytes always come
  // from snap so a multi-byte read sees one coherent value.
  always_comb begin
    rddata = 8'h00;
    for (int c = 0; c < NCHAN; c++) begin
      if (w_chsel[c]) begin
        if (int'(w_off) < NBYTE) begin
          if ((w_off == CH_OFF_CNT0) && !w_use_snap[c])
            rddata = count[c*CNTW +: 8];
          else
            rddata = 8'(w_snap[c*CNTW +: CNTW] >> {w_off, 3'b000});
        end else if (w_off == CH_OFF_CFG) begin
          rddata = configrd[c*8 +: 8];
        end
      end
    end
    if (w_glob) begin
      if (w_off == GL_OFF_HWCFG)     rddata = hwconfig;
      else if (w_off == GL_OFF_CTRL) rddata = controlrdata;
    end
  end

  assign pwmld     = r_pwmld;
  assign cfgld     = r_cfgld;
  assign freeze    = w_freeze;
  assign ctrlld    = r_ctrlld;
  assign wdogdivld = r_wdogdivld;
  assign wdreset   = r_wdreset;

endmodule

// File: tb/tb_chan_reg_bank.sv
// Directed bench for chan_reg_bank: a 16-bit and a 24-bit counter build
// share the SPI-side stimulus; each scenario checks its own outputs.
module tb_chan_reg_bank;

  logic        clk = 1'b0;
  logic        rst, wrt, rdt;
  logic [4:0]  addr;
  logic [47:0] count16;
  logic [71:0] count24;
  logic [23:0] configrd;
  logic [7:0]  hwconfig, controlrdata;

  logic [7:0]  rd16, rd24;
  logic [2:0]  pwmld16, cfgld16, freeze16, pwmld24, cfgld24, freeze24;
  logic        ctrlld16, wdogdivld16, wdreset16, ctrlld24, wdogdivld24, wdreset24;
  logic [8:0]  str16, str24;

  int total = 0;
  int bad   = 0;

  assign str16 = {pwmld16, cfgld16, ctrlld16, wdogdivld16, wdreset16};
  assign str24 = {pwmld24, cfgld24, ctrlld24, wdogdivld24, wdreset24};

  always #5 clk = ~clk;

  chan_reg_bank #(.NCHAN(3), .CNTW(16)) u_dut16 (
    .clk(clk), .rst(rst), .wrt(wrt), .rdt(rdt), .addr(addr), .count(count16),
    .configrd(configrd), .hwconfig(hwconfig), .controlrdata(controlrdata),
    .rddata(rd16), .pwmld(pwmld16), .cfgld(cfgld16), .freeze(freeze16),
    .ctrlld(ctrlld16), .wdogdivld(wdogdivld16), .wdreset(wdreset16)
  );

  chan_reg_bank #(.NCHAN(3), .CNTW(24)) u_dut24 (
    .clk(clk), .rst(rst), .wrt(wrt), .rdt(rdt), .addr(addr), .count(count24),
    .configrd(configrd), .hwconfig(hwconfig), .controlrdata(controlrdata),
    .rddata(rd24), .pwmld(pwmld24), .cfgld(cfgld24), .freeze(freeze24),
    .ctrlld(ctrlld24), .wdogdivld(wdogdivld24), .wdreset(wdreset24)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; wrt = 1'b0; rdt = 1'b0; addr = 5'h00;
    tick(3);
    total++; if (str16 !== 9'd0) begin bad++; $display("FAIL reset_str16 got=%b exp=%b", str16, 9'd0); end
    total++; if (str24 !== 9'd0) begin bad++; $display("FAIL reset_str24 got=%b exp=%b", str24, 9'd0); end
    total++; if ({freeze16, freeze24} !== 6'd0) begin bad++; $display("FAIL reset_freeze got=%b exp=%b", {freeze16, freeze24}, 6'd0); end
    rst = 1'b0;
    tick(1);
    count16[15:0] = 16'hBEEF;
    addr = 5'h00; #1;
    total++; if (rd16 !== 8'hEF) begin bad++; $display("FAIL reset_live_b0 got=%h exp=%h", rd16, 8'hEF); end
    addr = 5'h01; #1;
    total++; if (rd16 !== 8'h00) begin bad++; $display("FAIL reset_snap_b1 got=%h exp=%h", rd16, 8'h00); end
  endtask

  task automatic test_write_strobe;
    logic [4:0] a_tab [5] = '{5'h08, 5'h15, 5'h1A, 5'h19, 5'h03};
    logic [8:0] e_tab [5] = '{9'b010_000_0_0_0, 9'b000_100_0_0_0, 9'b000_000_1_0_0,
                              9'b000_000_0_1_0, 9'b000_000_0_0_0};
    for (int i = 0; i < 5; i++) begin
      addr = a_tab[i]; wrt = 1'b1;
      tick(4);
      total++; if (str16 !== 9'd0) begin bad++; $display("FAIL wr_rise_quiet a=%h got=%b exp=%b", a_tab[i], str16, 9'd0); end
      wrt = 1'b0;
      tick(2);
      total++; if (str16 !== 9'd0) begin bad++; $display("FAIL wr_early a=%h got=%b exp=%b", a_tab[i], str16, 9'd0); end
      tick(1);
      total++; if (str16 !== e_tab[i]) begin bad++; $display("FAIL wr_strobe16 a=%h got=%b exp=%b", a_tab[i], str16, e_tab[i]); end
      total++; if (str24 !== e_tab[i]) begin bad++; $display("FAIL wr_strobe24 a=%h got=%b exp=%b", a_tab[i], str24, e_tab[i]); end
      tick(1);
      total++; if (str16 !== 9'd0) begin bad++; $display("FAIL wr_width a=%h got=%b exp=%b", a_tab[i], str16, 9'd0); end
      tick(2);
    end
  endtask

  task automatic test_snapshot;
    count24[23:0] = 24'h1234FF; addr = 5'h00; rdt = 1'b1;
    tick(2);
    total++; if (freeze24 !== 3'b000) begin bad++; $display("FAIL snap_pre got=%b exp=%b", freeze24, 3'b000); end
    tick(1);
    total++; if (freeze24 !== 3'b001) begin bad++; $display("FAIL snap_hold got=%b exp=%b", freeze24, 3'b001); end
    total++; if (rd24 !== 8'hFF) begin bad++; $display("FAIL snap_hold_b0 got=%h exp=%h", rd24, 8'hFF); end
    tick(1);
    total++; if (freeze24 !== 3'b001) begin bad++; $display("FAIL snap_capt got=%b exp=%b", freeze24, 3'b001); end
    tick(1);
    total++; if (freeze24 !== 3'b000) begin bad++; $display("FAIL snap_lock got=%b exp=%b", freeze24, 3'b000); end
    count24[23:0] = 24'h123500; #1;
    total++; if (rd24 !== 8'hFF) begin bad++; $display("FAIL snap_lock_b0 got=%h exp=%h", rd24, 8'hFF); end
    rdt = 1'b0;
    tick(4);
    addr = 5'h01; #1;
    total++; if (rd24 !== 8'h34) begin bad++; $display("FAIL snap_b1 got=%h exp=%h", rd24, 8'h34); end
    addr = 5'h02; #1;
    total++; if (rd24 !== 8'h12) begin bad++; $display("FAIL snap_b2 got=%h exp=%h", rd24, 8'h12); end
    addr = 5'h00; #1;
    total++; if (rd24 !== 8'h00) begin bad++; $display("FAIL snap_idle_b0 got=%h exp=%h", rd24, 8'h00); end
  endtask

  task automatic test_relock;
    count24[47:24] = 24'hABCDEF; addr = 5'h08; rdt = 1'b1;
    tick(2);
    rdt = 1'b0;
    tick(1);
    total++; if (freeze24 !== 3'b010) begin bad++; $display("FAIL relock_hold got=%b exp=%b", freeze24, 3'b010); end
    rdt = 1'b1;
    tick(1);
    total++; if (freeze24 !== 3'b010) begin bad++; $display("FAIL relock_capt got=%b exp=%b", freeze24, 3'b010); end
    tick(1);
    count24[47:24] = 24'h112233;
    for (int i = 0; i < 4; i++) begin
      total++; if (freeze24 !== 3'b000) begin bad++; $display("FAIL relock_ignored i=%0d got=%b exp=%b", i, freeze24, 3'b000); end
      tick(1);
    end
    total++; if (rd24 !== 8'hEF) begin bad++; $display("FAIL relock_b0 got=%h exp=%h", rd24, 8'hEF); end
    addr = 5'h09; #1;
    total++; if (rd24 !== 8'hCD) begin bad++; $display("FAIL relock_b1 got=%h exp=%h", rd24, 8'hCD); end
    addr = 5'h0A; #1;
    total++; if (rd24 !== 8'hAB) begin bad++; $display("FAIL relock_b2 got=%h exp=%h", rd24, 8'hAB); end
    addr = 5'h08; rdt = 1'b0;
    tick(4);
    rdt = 1'b1;
    tick(6);
    rdt = 1'b0;
    tick(4);
    addr = 5'h0A; #1;
    total++; if (rd24 !== 8'h11) begin bad++; $display("FAIL renew_b2 got=%h exp=%h", rd24, 8'h11); end
    addr = 5'h09; #1;
    total++; if (rd24 !== 8'h22) begin bad++; $display("FAIL renew_b1 got=%h exp=%h", rd24, 8'h22); end
  endtask

  task automatic test_rst_abort;
    count24[23:0] = 24'h0A0B0C; addr = 5'h00; rdt = 1'b1;
    tick(4);
    total++; if (freeze24 !== 3'b001) begin bad++; $display("FAIL abort_capt got=%b exp=%b", freeze24, 3'b001); end
    rst = 1'b1; rdt = 1'b0;
    tick(1);
    total++; if (freeze24 !== 3'b000) begin bad++; $display("FAIL abort_freeze got=%b exp=%b", freeze24, 3'b000); end
    total++; if (rd24 !== 8'h0C) begin bad++; $display("FAIL abort_idle_b0 got=%h exp=%h", rd24, 8'h0C); end
    addr = 5'h01; #1;
    total++; if (rd24 !== 8'h00) begin bad++; $display("FAIL abort_snap_b1 got=%h exp=%h", rd24, 8'h00); end
    addr = 5'h02; #1;
    total++; if (rd24 !== 8'h00) begin bad++; $display("FAIL abort_snap_b2 got=%h exp=%h", rd24, 8'h00); end
    rst = 1'b0;
    tick(3);
    total++; if (freeze24 !== 3'b000) begin bad++; $display("FAIL abort_after got=%b exp=%b", freeze24, 3'b000); end
  endtask

  task automatic test_global_read;
    controlrdata = 8'h5C; addr = 5'h1A; #1;
    total++; if (rd16 !== 8'h5C) begin bad++; $display("FAIL glob_ctrl_rd got=%h exp=%h", rd16, 8'h5C); end
    rdt = 1'b1;
    tick(2);
    total++; if (wdreset16 !== 1'b0) begin bad++; $display("FAIL wdreset_early got=%b exp=%b", wdreset16, 1'b0); end
    tick(1);
    total++; if (str16 !== 9'b000_000_0_0_1) begin bad++; $display("FAIL wdreset_pulse got=%b exp=%b", str16, 9'b000_000_0_0_1); end
    tick(1);
    total++; if (wdreset16 !== 1'b0) begin bad++; $display("FAIL wdreset_width got=%b exp=%b", wdreset16, 1'b0); end
    rdt = 1'b0;
    tick(4);
    addr = 5'h07; #1;
    total++; if ({rd16, rd24} !== 16'h0000) begin bad++; $display("FAIL unmapped_07 got=%h exp=%h", {rd16, rd24}, 16'h0000); end
    addr = 5'h18; #1;
    total++; if (rd16 !== 8'hA5) begin bad++; $display("FAIL glob_hwcfg got=%h exp=%h", rd16, 8'hA5); end
    addr = 5'h0D; #1;
    total++; if (rd16 !== 8'h62) begin bad++; $display("FAIL ch1_cfg got=%h exp=%h", rd16, 8'h62); end
    addr = 5'h03; #1;
    total++; if ({rd16, rd24} !== 16'h0000) begin bad++; $display("FAIL ch0_off3 got=%h exp=%h", {rd16, rd24}, 16'h0000); end
    addr = 5'h1F; #1;
    total++; if (rd16 !== 8'h00) begin bad++; $display("FAIL glob_off7 got=%h exp=%h", rd16, 8'h00); end
  endtask

  task automatic test_reset_wrt_high;
    int n_pulse = 0;
    int n_other = 0;
    addr = 5'h19; wrt = 1'b1; rst = 1'b1;
    tick(2);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick(1);
      if (str16 !== 9'd0) n_other++;
    end
    wrt = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      if (str16 === 9'b000_000_0_1_0) n_pulse++;
      else if (str16 !== 9'd0) n_other++;
    end
    total++; if (n_pulse != 1) begin bad++; $display("FAIL wdog_pulses got=%0d exp=%0d", n_pulse, 1); end
    total++; if (n_other != 0) begin bad++; $display("FAIL wdog_stray got=%0d exp=%0d", n_other, 0); end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; wrt = 1'b0; rdt = 1'b0; addr = '0;
    count16 = '0; count24 = '0;
    configrd = 24'h736251; hwconfig = 8'hA5; controlrdata = 8'h00;
    test_reset;
    test_write_strobe;
    test_snapshot;
    test_relock;
    test_rst_abort;
    test_global_read;
    test_reset_wrt_high;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
